// File: rtl/spi_slave_axis_ingress.sv
// SPI slave MOSI receive path: samples MOSI on posedge spi_clk, packs bytes and
// presents them on an 8-bit AXI-Stream master with first-byte (tuser) and MTU-end (tlast) markers.
module spi_slave_axis_ingress #(
   parameter int MSB_FIRST       = 1,
   parameter int MOSI_SIZE       = 1,
   parameter int MTU_SIZE        = 16,
   parameter int USE_CHIP_SELECT = 0
) (
   input  logic                 spi_clk,
   input  logic                 resn,
   input  logic                 spi_csn,
   input  logic [MOSI_SIZE-1:0] spi_mosi,
   output logic [7:0]           m_axis_tdata,
   output logic                 m_axis_tvalid,
   input  logic                 m_axis_tready,
   output logic                 m_axis_tuser,
   output logic                 m_axis_tlast,
   output logic                 overflow
);
   localparam int FW = (MTU_SIZE > 1) ? $clog2(MTU_SIZE) : 1;

   if (MOSI_SIZE != 1 && MOSI_SIZE != 2) begin : g_bad_mosi
      $error("spi_slave_axis_ingress: MOSI_SIZE must be 1 or 2");
   end

   logic [7:0]    r_sh;
   logic [2:0]    r_bit_cnt;
   logic [FW-1:0] r_frame_cnt;
   logic          r_first_pending;
   logic [7:0]    r_tdata;
   logic          r_tvalid;
   logic          r_tuser;
   logic          r_tlast;
   logic          r_overflow;

   logic [7:0]    w_shift;
   logic          w_cs_active;
   logic          w_last_bits;
   logic          w_frame_last;
   logic          w_can_load;

   // Shifted value including the bits sampled on this edge.
   if (MSB_FIRST != 0) begin : g_msb
      assign w_shift = {r_sh[7-MOSI_SIZE:0], spi_mosi};
   end else begin : g_lsb
      assign w_shift = {spi_mosi, r_sh[7:MOSI_SIZE]};
   end

   assign w_cs_active  = (USE_CHIP_SELECT == 0) || !spi_csn;
   assign w_last_bits  = (r_bit_cnt == 3'(8 - MOSI_SIZE));
   assign w_frame_last = (r_frame_cnt == FW'(MTU_SIZE - 1));
   assign w_can_load   = !r_tvalid || m_axis_tready;

   always_ff @(posedge spi_clk) begin
      if (!resn) begin
         r_sh            <= '0;
         r_bit_cnt       <= '0;
         r_frame_cnt     <= '0;
         r_first_pending <= 1'b1;
         r_tdata         <= '0;
         r_tvalid        <= 1'b0;
         r_tuser         <= 1'b0;
         r_tlast         <= 1'b0;
         r_overflow      <= 1'b0;
      end else begin
         if (r_tvalid && m_axis_tready)
            r_tvalid <= 1'b0;

         if (!w_cs_active) begin
            r_sh            <= '0;
            r_bit_cnt       <= '0;
            r_frame_cnt     <= '0;
            r_first_pending <= 1'b1;
         end else begin
            r_sh      <= w_shift;
            r_bit_cnt <= r_bit_cnt + 3'(MOSI_SIZE);
            if (w_last_bits) begin
               // A completing byte overrides the acceptance clear above: no bubble.
               if (w_can_load) begin
                  r_tdata  <= w_shift;
                  r_tvalid <= 1'b1;
                  r_tuser  <= r_first_pending;
                  r_tlast  <= w_frame_last;
               end else begin
                  r_overflow <= 1'b1;
               end
               // Dropped bytes still count so framing stays aligned with the host.
               if (w_frame_last) begin
                  r_frame_cnt     <= '0;
                  r_first_pending <= 1'b1;
               end else begin
                  r_frame_cnt     <= r_frame_cnt + FW'(1);
                  r_first_pending <= 1'b0;
               end
            end
         end
      end
   end

   assign m_axis_tdata  = r_tdata;
   assign m_axis_tvalid = r_tvalid;
   assign m_axis_tuser  = r_tuser;
   assign m_axis_tlast  = r_tlast;
   assign overflow      = r_overflow;
endmodule

// File: tb/tb_spi_slave_axis_ingress.sv
// Scoreboard bench for spi_slave_axis_ingress: three configurations, expected beats
// queued at stimulus time and popped by per-instance monitors on the falling edge.
module tb_spi_slave_axis_ingress;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   // u0: MSB first, single lane, MTU 4, chip select used
   logic       rst0 = 1'b0, csn0 = 1'b1, mosi0 = 1'b0, rdy0 = 1'b1;
   logic [7:0] td0;
   logic       tv0, tu0, tl0, ov0;
   spi_slave_axis_ingress #(.MSB_FIRST(1), .MOSI_SIZE(1), .MTU_SIZE(4), .USE_CHIP_SELECT(1)) u0 (
      .spi_clk(clk), .resn(rst0), .spi_csn(csn0), .spi_mosi(mosi0),
      .m_axis_tdata(td0), .m_axis_tvalid(tv0), .m_axis_tready(rdy0),
      .m_axis_tuser(tu0), .m_axis_tlast(tl0), .overflow(ov0));

   // u1: LSB first, dual lane, MTU 16, chip select ignored
   logic       rst1 = 1'b0, csn1 = 1'b1, rdy1 = 1'b1;
   logic [1:0] mosi1 = 2'b00;
   logic [7:0] td1;
   logic       tv1, tu1, tl1, ov1;
   spi_slave_axis_ingress #(.MSB_FIRST(0), .MOSI_SIZE(2), .MTU_SIZE(16), .USE_CHIP_SELECT(0)) u1 (
      .spi_clk(clk), .resn(rst1), .spi_csn(csn1), .spi_mosi(mosi1),
      .m_axis_tdata(td1), .m_axis_tvalid(tv1), .m_axis_tready(rdy1),
      .m_axis_tuser(tu1), .m_axis_tlast(tl1), .overflow(ov1));

   // u2: LSB first, single lane, MTU 1
   logic       rst2 = 1'b0, csn2 = 1'b1, mosi2 = 1'b0, rdy2 = 1'b1;
   logic [7:0] td2;
   logic       tv2, tu2, tl2, ov2;
   spi_slave_axis_ingress #(.MSB_FIRST(0), .MOSI_SIZE(1), .MTU_SIZE(1), .USE_CHIP_SELECT(0)) u2 (
      .spi_clk(clk), .resn(rst2), .spi_csn(csn2), .spi_mosi(mosi2),
      .m_axis_tdata(td2), .m_axis_tvalid(tv2), .m_axis_tready(rdy2),
      .m_axis_tuser(tu2), .m_axis_tlast(tl2), .overflow(ov2));

   // expected beat = {tdata, tuser, tlast}
   logic [9:0] q0[$], q1[$], q2[$];

   task automatic mon(input string nm, inout logic [9:0] q[$], input logic [9:0] act);
      logic [9:0] e;
      if (q.size() == 0) begin
         n_total++;
         $display("FAIL %s_extra_beat: got %0h expected no beat", nm, act);
      end else begin
         e = q.pop_front();
         chk(nm, 32'(act), 32'(e));
      end
   endtask

   always @(negedge clk) if (tv0 && rdy0) mon("u0_beat", q0, {td0, tu0, tl0});
   always @(negedge clk) if (tv1 && rdy1) mon("u1_beat", q1, {td1, tu1, tl1});
   always @(negedge clk) if (tv2 && rdy2) mon("u2_beat", q2, {td2, tu2, tl2});

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send0(input logic [7:0] b, input int n);
      for (int i = 0; i < n; i++) begin
         mosi0 = b[7-i];
         tick();
      end
   endtask

   task automatic send1(input logic [7:0] b);
      for (int i = 0; i < 4; i++) begin
         mosi1 = b[2*i +: 2];
         tick();
      end
   endtask

   task automatic send2(input logic [7:0] b);
      for (int i = 0; i < 8; i++) begin
         mosi2 = b[i];
         tick();
      end
   endtask

   task automatic csn0_pulse();
      csn0 = 1'b1;
      tick();
      csn0 = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) tick();
      chk("rst_tdata",    32'(td0), 32'h0);
      chk("rst_tvalid",   32'(tv0), 32'h0);
      chk("rst_tuser",    32'(tu0), 32'h0);
      chk("rst_tlast",    32'(tl0), 32'h0);
      chk("rst_overflow", 32'(ov0), 32'h0);
      chk("rst_tvalid_u1", 32'(tv1), 32'h0);

      // dual lane, LSB pair first; csn high must be ignored
      rst1 = 1'b1;
      q1.push_back({8'hA5, 1'b1, 1'b0}); send1(8'hA5);
      q1.push_back({8'h3C, 1'b0, 1'b0}); send1(8'h3C);
      rst1 = 1'b0;
      tick();

      // MTU 1: every byte is both first and last
      rst2 = 1'b1;
      q2.push_back({8'h5A, 1'b1, 1'b1}); send2(8'h5A);
      q2.push_back({8'hC3, 1'b1, 1'b1}); send2(8'hC3);
      rst2 = 1'b0;
      tick();

      // u0 single byte, MSB first
      rst0 = 1'b1;
      tick();
      csn0 = 1'b0;
      q0.push_back({8'hA5, 1'b1, 1'b0}); send0(8'hA5, 8);
      tick();
      chk("t1_tvalid_one_cycle", 32'(tv0), 32'h0);

      // partial byte discarded by a csn-high edge, frame restarts
      send0(8'hE0, 3);
      csn0_pulse();
      q0.push_back({8'h3C, 1'b1, 1'b0}); send0(8'h3C, 8);

      // MTU 4 framing
      csn0_pulse();
      q0.push_back({8'h01, 1'b1, 1'b0}); send0(8'h01, 8);
      q0.push_back({8'h02, 1'b0, 1'b0}); send0(8'h02, 8);
      q0.push_back({8'h03, 1'b0, 1'b0}); send0(8'h03, 8);
      q0.push_back({8'h04, 1'b0, 1'b1}); send0(8'h04, 8);
      q0.push_back({8'h05, 1'b1, 1'b0}); send0(8'h05, 8);
      q0.push_back({8'h06, 1'b0, 1'b0}); send0(8'h06, 8);

      // back-pressure: second byte dropped
      csn0_pulse();
      rdy0 = 1'b0;
      q0.push_back({8'h11, 1'b1, 1'b0}); send0(8'h11, 8);
      send0(8'h22, 8);
      chk("t3_overflow", 32'(ov0), 32'h1);
      chk("t3_tvalid",   32'(tv0), 32'h1);
      chk("t3_tdata",    32'(td0), 32'h11);
      rdy0 = 1'b1;
      tick();
      chk("t3_tvalid_after_accept", 32'(tv0), 32'h0);
      chk("t3_overflow_sticky",     32'(ov0), 32'h1);

      // reset mid-byte
      send0(8'hFF, 5);
      rst0 = 1'b0;
      tick();
      chk("t6_rst_tdata",    32'(td0), 32'h0);
      chk("t6_rst_tvalid",   32'(tv0), 32'h0);
      chk("t6_rst_tuser",    32'(tu0), 32'h0);
      chk("t6_rst_tlast",    32'(tl0), 32'h0);
      chk("t6_rst_overflow", 32'(ov0), 32'h0);
      rst0 = 1'b1;
      q0.push_back({8'h7E, 1'b1, 1'b0}); send0(8'h7E, 8);
      repeat (3) tick();
      chk("t6_overflow", 32'(ov0), 32'h0);

      chk("q0_drained", 32'(q0.size()), 32'h0);
      chk("q1_drained", 32'(q1.size()), 32'h0);
      chk("q2_drained", 32'(q2.size()), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
